// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: turns symbolic instruction requests into
// 32-bit MIPS words (R, addi, lw, sw, andi, beq, jal) and writes them into
// instruction memory at sequential word addresses starting at BASE_ADDR.
// One request is accepted every two cycles at most; the block stops
// accepting once the last address has been written, until clear or reset.
module instr_encoder_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op_sel,
   input  logic [5:0]        funct,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_FULL
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] ptr;
   logic              accept;
   logic              legal;

   // Only the five ALU functions the control unit decodes are accepted.
   function automatic logic funct_ok(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
         default:                                               funct_ok = 1'b0;
      endcase
   endfunction

   // Field packing per instruction class; fields a class does not use are dropped.
   function automatic logic [31:0] encode(input logic [2:0]  op,
                                          input logic [5:0]  f,
                                          input logic [4:0]  s,
                                          input logic [4:0]  t,
                                          input logic [4:0]  d,
                                          input logic [15:0] im,
                                          input logic [25:0] tg);
      case (op)
         3'd0:    encode = {6'b000000, s, t, d, 5'b00000, f};
         3'd1:    encode = {6'b001000, s, t, im};
         3'd2:    encode = {6'b100011, s, t, im};
         3'd3:    encode = {6'b101011, s, t, im};
         3'd4:    encode = {6'b001100, s, t, im};
         3'd5:    encode = {6'b000100, s, t, im};
         3'd6:    encode = {6'b000011, tg};
         default: encode = 32'h0000_0000;
      endcase
   endfunction

   assign in_ready = (state == S_IDLE) && !full && !clear && !reset;
   assign accept   = in_valid && in_ready;
   assign legal    = (op_sel != 3'd7) && ((op_sel != 3'd0) || funct_ok(funct));
   // An aborted write (clear or reset during WRITE) never strobes memory.
   assign mem_we   = (state == S_WRITE) && !clear && !reset;

   // State register; reset returns to IDLE.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic; clear overrides every transition.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept && legal) state_nx = S_WRITE;
         S_WRITE: state_nx = (ptr == LAST) ? S_FULL : S_IDLE;
         S_FULL:  state_nx = S_FULL;
         default: state_nx = S_IDLE;
      endcase
      if (clear) state_nx = S_IDLE;
   end

   // Control: write pointer, word count, full and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         ptr   <= BASE;
         count <= '0;
         full  <= 1'b0;
         err   <= 1'b0;
      end else begin
         if (accept && !legal) err <= 1'b1;
         if (state == S_WRITE) begin
            count <= count + (ADDR_W+1)'(1);
            if (ptr == LAST) full <= 1'b1;
            else             ptr  <= ptr + ADDR_W'(1);
         end
      end
   end

   // Write address/data captured at the handshake and held until the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr  <= BASE;
         mem_wdata <= 32'h0000_0000;
      end else if (accept && legal) begin
         mem_addr  <= ptr;
         mem_wdata <= encode(op_sel, funct, rs, rt, rd, imm, target);
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a 256-word instance and a 4-word instance
// share request fields; sel picks which one receives in_valid and is observed.
// Expected behaviour comes from a transaction-level model of the loader.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  op_sel = '0;
   logic [5:0]  funct = '0;
   logic [4:0]  rs = '0;
   logic [4:0]  rt = '0;
   logic [4:0]  rd = '0;
   logic [15:0] imm = '0;
   logic [25:0] target = '0;
   logic        sel = 1'b0;

   logic        va, vb;
   logic        rdy_a, rdy_b, we_a, we_b, full_a, full_b, err_a, err_b;
   logic [7:0]  addr_a;
   logic [1:0]  addr_b;
   logic [31:0] wd_a, wd_b;
   logic [8:0]  cnt_a;
   logic [2:0]  cnt_b;

   logic        o_ready, o_we, o_full, o_err;
   logic [7:0]  o_addr;
   logic [31:0] o_wdata;
   logic [8:0]  o_count;

   int n_cmp = 0;
   int n_bad = 0;

   // transaction-level model state
   int          m_cap;
   int          m_ptr;
   int          m_count;
   bit          m_full;
   bit          m_err;
   int          m_last_addr;
   logic [31:0] m_last_word;
   logic [31:0] obs_words[$];
   int          obs_addrs[$];

   always #5 clk = ~clk;

   assign va = in_valid & ~sel;
   assign vb = in_valid & sel;
   assign o_ready = sel ? rdy_b  : rdy_a;
   assign o_we    = sel ? we_b   : we_a;
   assign o_full  = sel ? full_b : full_a;
   assign o_err   = sel ? err_b  : err_a;
   assign o_addr  = sel ? {6'd0, addr_b} : addr_a;
   assign o_wdata = sel ? wd_b : wd_a;
   assign o_count = sel ? {6'd0, cnt_b} : cnt_a;

   instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut_a (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(va), .in_ready(rdy_a),
      .op_sel(op_sel), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
      .target(target), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
      .count(cnt_a), .full(full_a), .err(err_a)
   );

   instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_dut_b (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(vb), .in_ready(rdy_b),
      .op_sel(op_sel), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
      .target(target), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
      .count(cnt_b), .full(full_b), .err(err_b)
   );

   function automatic bit model_legal(input int op, input int fn);
      int ok_fn[5] = '{32, 34, 36, 37, 42};
      if (op == 7) return 1'b0;
      if (op != 0) return 1'b1;
      foreach (ok_fn[i]) if (fn == ok_fn[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_word(input int op, input int fn, input int s,
                                              input int t, input int d, input int im,
                                              input int tg);
      longint opc[7] = '{0, 8, 35, 43, 12, 4, 3};
      longint w;
      w = opc[op] * 64'd67108864;
      if (op == 6) w = w + tg;
      else begin
         w = w + s * 64'd2097152 + t * 64'd65536;
         if (op == 0) w = w + d * 64'd2048 + fn;
         else         w = w + im;
      end
      return w[31:0];
   endfunction

   task automatic model_clear();
      m_ptr = 0; m_count = 0; m_full = 0; m_err = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      model_clear();
      m_last_addr = 0;
      m_last_word = 32'h0;
      m_cap = sel ? 4 : 256;
      obs_words.delete();
      obs_addrs.delete();
   endtask

   // Issue one request starting at a negedge; ends at a negedge. keep leaves
   // in_valid high so the next call continues back-to-back.
   task automatic drive_req(input int op, input int fn, input int s, input int t,
                            input int d, input int im, input int tg, input bit keep);
      logic [31:0] w;
      op_sel = 3'(op); funct = 6'(fn); rs = 5'(s); rt = 5'(t); rd = 5'(d);
      imm = 16'(im); target = 26'(tg); in_valid = 1'b1;
      #1;
      if (m_full) begin
         n_cmp++;
         if (o_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", o_ready); end
         repeat (10) begin
            @(posedge clk); @(negedge clk); #1;
            n_cmp++;
            if (o_we !== 1'b0) begin n_bad++; $display("FAIL full_no_write: mem_we got %b want 0", o_we); end
         end
         in_valid = 1'b0;
      end else begin
         n_cmp++;
         if (o_ready !== 1'b1) begin n_bad++; $display("FAIL ready_idle: got %b want 1", o_ready); end
         @(posedge clk); @(negedge clk);
         if (!keep) in_valid = 1'b0;
         #1;
         if (model_legal(op, fn)) begin
            w = model_word(op, fn, s, t, d, im, tg);
            n_cmp++;
            if (o_we !== 1'b1) begin n_bad++; $display("FAIL write_we: got %b want 1", o_we); end
            n_cmp++;
            if (o_addr !== 8'(m_ptr)) begin n_bad++; $display("FAIL write_addr: got %0d want %0d", o_addr, m_ptr); end
            n_cmp++;
            if (o_wdata !== w) begin n_bad++; $display("FAIL write_data: got %h want %h", o_wdata, w); end
            n_cmp++;
            if (o_ready !== 1'b0) begin n_bad++; $display("FAIL ready_in_write: got %b want 0", o_ready); end
            obs_words.push_back(o_wdata);
            obs_addrs.push_back(int'(o_addr));
            m_last_addr = m_ptr;
            m_last_word = w;
            m_count++;
            if (m_ptr == m_cap - 1) m_full = 1'b1;
            else                    m_ptr++;
            @(posedge clk); @(negedge clk); #1;
            n_cmp++;
            if (o_we !== 1'b0) begin n_bad++; $display("FAIL we_one_cycle: got %b want 0", o_we); end
            n_cmp++;
            if (o_count !== 9'(m_count)) begin n_bad++; $display("FAIL count: got %0d want %0d", o_count, m_count); end
            n_cmp++;
            if (o_full !== m_full) begin n_bad++; $display("FAIL full_flag: got %b want %b", o_full, m_full); end
            n_cmp++;
            if (o_ready !== !m_full) begin n_bad++; $display("FAIL ready_after: got %b want %b", o_ready, !m_full); end
         end else begin
            m_err = 1'b1;
            n_cmp++;
            if (o_we !== 1'b0) begin n_bad++; $display("FAIL illegal_we: got %b want 0", o_we); end
            n_cmp++;
            if (o_count !== 9'(m_count)) begin n_bad++; $display("FAIL illegal_count: got %0d want %0d", o_count, m_count); end
            n_cmp++;
            if (o_ready !== 1'b1) begin n_bad++; $display("FAIL illegal_ready: got %b want 1", o_ready); end
         end
         n_cmp++;
         if (o_addr !== 8'(m_last_addr)) begin n_bad++; $display("FAIL addr_hold: got %0d want %0d", o_addr, m_last_addr); end
         n_cmp++;
         if (o_wdata !== m_last_word) begin n_bad++; $display("FAIL data_hold: got %h want %h", o_wdata, m_last_word); end
      end
      n_cmp++;
      if (o_err !== m_err) begin n_bad++; $display("FAIL err_flag: got %b want %b", o_err, m_err); end
   endtask

   task automatic test_reset();
      sel = 1'b0;
      do_reset();
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", o_ready); end
      n_cmp++; if (o_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", o_we); end
      n_cmp++; if (o_addr !== 8'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", o_addr); end
      n_cmp++; if (o_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", o_wdata); end
      n_cmp++; if (o_count !== 9'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", o_count); end
      n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", o_full); end
      n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", o_err); end
   endtask

   task automatic test_addi();
      sel = 1'b0;
      do_reset();
      drive_req(1, 0, 1, 2, 0, 16'h0005, 0, 1'b0);
      n_cmp++;
      if (obs_words.size() != 1 || obs_words[0] !== 32'h20220005) begin
         n_bad++; $display("FAIL addi_word: got %0d words, first %h want 20220005", obs_words.size(),
                           obs_words.size() > 0 ? obs_words[0] : 32'h0);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] want[4] = '{32'h00221820, 32'h8FA80004, 32'h1085FFFF, 32'h0C000010};
      sel = 1'b0;
      do_reset();
      drive_req(0, 6'b100000, 1, 2, 3, 0, 0, 1'b1);
      drive_req(2, 0, 29, 8, 0, 16'h0004, 0, 1'b1);
      drive_req(5, 0, 4, 5, 0, 16'hFFFF, 0, 1'b1);
      drive_req(6, 0, 0, 0, 0, 0, 26'h0000010, 1'b0);
      n_cmp++;
      if (obs_words.size() != 4) begin
         n_bad++; $display("FAIL b2b_count: got %0d writes want 4", obs_words.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs_words[i] !== want[i] || obs_addrs[i] != i) begin
               n_bad++; $display("FAIL b2b_word%0d: got %h@%0d want %h@%0d", i, obs_words[i], obs_addrs[i], want[i], i);
            end
         end
      end
   endtask

   task automatic test_illegal();
      sel = 1'b0;
      do_reset();
      drive_req(7, 0, 3, 4, 5, 16'h1234, 0, 1'b0);
      drive_req(0, 6'b100001, 1, 2, 3, 0, 0, 1'b0);
      drive_req(3, 0, 0, 9, 0, 16'h0010, 0, 1'b0);
      n_cmp++;
      if (obs_words.size() != 1 || obs_words[0] !== 32'hAC090010 || obs_addrs[0] != 0) begin
         n_bad++; $display("FAIL illegal_then_sw: got %0d writes, first %h want AC090010@0", obs_words.size(),
                           obs_words.size() > 0 ? obs_words[0] : 32'h0);
      end
      n_cmp++;
      if (o_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", o_err); end
   endtask

   task automatic test_full_and_clear();
      sel = 1'b1;
      do_reset();
      drive_req(7, 0, 0, 0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         drive_req(1 + (i % 5), 0, i + 1, i + 2, 0, 16'h0100 + i, 0, 1'b0);
      n_cmp++;
      if (o_full !== 1'b1 || o_count !== 9'd4) begin
         n_bad++; $display("FAIL full_after4: got full=%b count=%0d want full=1 count=4", o_full, o_count);
      end
      drive_req(1, 0, 7, 7, 0, 16'h7777, 0, 1'b0);
      // clear while FULL, colliding with a valid request
      @(negedge clk);
      clear = 1'b1; in_valid = 1'b1; op_sel = 3'd1; imm = 16'h0abc;
      #1;
      n_cmp++;
      if (o_ready !== 1'b0) begin n_bad++; $display("FAIL clear_ready: got %b want 0", o_ready); end
      @(posedge clk); @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      #1;
      model_clear();
      n_cmp++; if (o_we !== 1'b0) begin n_bad++; $display("FAIL clear_no_write: got %b want 0", o_we); end
      n_cmp++; if (o_count !== 9'd0) begin n_bad++; $display("FAIL clear_count: got %0d want 0", o_count); end
      n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL clear_full: got %b want 0", o_full); end
      n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL clear_err: got %b want 0", o_err); end
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL clear_ready_after: got %b want 1", o_ready); end
      obs_addrs.delete();
      drive_req(4, 0, 2, 3, 0, 16'h00ff, 0, 1'b0);
      n_cmp++;
      if (obs_addrs.size() != 1 || obs_addrs[0] != 0) begin
         n_bad++; $display("FAIL clear_restart_addr: got %0d writes want one at 0", obs_addrs.size());
      end
      sel = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      sel = 1'b0;
      do_reset();
      drive_req(1, 0, 1, 1, 0, 16'h0001, 0, 1'b0);
      @(negedge clk);
      op_sel = 3'd2; rs = 5'd3; rt = 5'd4; imm = 16'h0040; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      reset = 1'b1; in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++; if (o_we !== 1'b0) begin n_bad++; $display("FAIL rstw_we: got %b want 0", o_we); end
      n_cmp++; if (o_count !== 9'd0) begin n_bad++; $display("FAIL rstw_count: got %0d want 0", o_count); end
      n_cmp++; if (o_addr !== 8'd0) begin n_bad++; $display("FAIL rstw_addr: got %0d want 0", o_addr); end
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rstw_ready: got %b want 1", o_ready); end
   endtask

   task automatic test_random();
      int legal_fn[5] = '{32, 34, 36, 37, 42};
      int op, fn;
      sel = 1'b0;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) fn = int'($urandom_range(0, 63));
         else                           fn = legal_fn[$urandom_range(0, 4)];
         drive_req(op, fn, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)),
                   int'($urandom_range(0, 67108863)), (i != 59) && ($urandom_range(0, 1) == 1));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_cap = 256;
      test_reset();
      test_addi();
      test_back_to_back();
      test_illegal();
      test_full_and_clear();
      test_reset_mid_write();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the opcode decoder. It accepts symbolic instruction requests (operation class plus fields) over a valid/ready handshake and encodes each one into a 32-bit MIPS word of the supported subset (R, addi, lw, sw, andi, beq, jal). Each word is written into instruction memory at a sequential word address. It sits beside instruction memory and lets the testbench or boot logic load programs that the control unit then decodes.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
BASE_ADDR, 0, first word address written after reset or clear; must be less than 2^ADDR_W

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous restart: pointer back to BASE_ADDR, count/full/err cleared
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
op_sel  input  3  0=R, 1=addi, 2=lw, 3=sw, 4=andi, 5=beq, 6=jal, 7=illegal
funct  input  6  R-type funct; legal values 100000, 100010, 100100, 100101, 101010
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register (R only)
imm  input  16  I-type immediate/offset, passed through verbatim
target  input  26  jal target field
mem_we  output  1  one-cycle write strobe to instruction memory
mem_addr  output  ADDR_W  word address for the write
mem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written since reset/clear
full  output  1  last address written; no further accepts
err  output  1  sticky: an illegal request was rejected

Behaviour:
- Reset: state=IDLE, ptr=BASE_ADDR, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0. in_ready=1 in the first cycle after reset.
- in_ready is combinational: (state==IDLE) & !full & !clear & !reset.
- A handshake occurs when in_valid & in_ready at a rising edge.
- Encoding, registered at the handshake edge:
  - R: {000000, rs, rt, rd, 00000, funct}
  - addi: {001000, rs, rt, imm}
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - andi: {001100, rs, rt, imm}
  - beq: {000100, rs, rt, imm}
  - jal: {000011, target}
  - Unused fields are ignored.
- FSM states: IDLE, WRITE, FULL.
  - IDLE, legal handshake: latch mem_wdata and mem_addr=ptr, go to WRITE.
  - IDLE, illegal handshake (op_sel=7, or R with a funct outside the legal list): request consumed, no write, err<=1, stay in IDLE.
  - WRITE: mem_we=1 for exactly this one cycle; count+=1.
    - If ptr == 2^ADDR_W-1: full<=1, go to FULL.
    - Otherwise: ptr+=1, go to IDLE.
  - FULL: in_ready=0, mem_we=0. Only clear or reset leaves FULL; there is no wrap-around.
- Latency: handshake at edge N; mem_we high during cycle N+1. Maximum throughput is one request per 2 cycles (in_ready=0 while in WRITE).
- mem_addr and mem_wdata hold their last values while mem_we=0.
- clear (outside reset): next state=IDLE, ptr=BASE_ADDR, count=0, full=0, err=0, mem_we=0.
  - A write in progress (WRITE) is aborted and not counted.
  - clear asserted together with in_valid: clear wins, no handshake.
- reset has priority over clear. Reset mid-WRITE: mem_we=0 in the next cycle, count=0.
- count saturates naturally at 2^ADDR_W; it cannot exceed capacity because FULL blocks further accepts.

Test Plan:
- Reset, then addi rs=1 rt=2 imm=0x0005 -> in_ready=0 the next cycle; mem_we=1 for 1 cycle; mem_addr=0; mem_wdata=0x20220005; count=1; in_ready=1 after.
- Back-to-back with in_valid held high: R add rs=1 rt=2 rd=3 funct=100000, then lw rs=29 rt=8 imm=0x0004, then beq rs=4 rt=5 imm=0xFFFF, then jal target=0x0000010 -> accepts every 2 cycles; addresses 0,1,2,3; words 0x00221820, 0x8FA80004, 0x1085FFFF, 0x0C000010.
- Illegal requests: op_sel=7, then R with funct=100001 -> no mem_we; err=1 and sticky; count unchanged. A following legal sw rs=0 rt=9 imm=0x0010 writes 0xAC090010 with err still 1.
- ADDR_W=2, BASE_ADDR=0: four legal requests -> addresses 0..3; full=1 after the fourth write; count=4; in_ready=0; a fifth in_valid held 10 cycles produces no mem_we.
- clear while in FULL, and clear in the same cycle as in_valid -> no handshake that cycle; next cycle ptr=0, count=0, full=0, err=0, in_ready=1. The next request writes address 0.
- Reset asserted in the WRITE cycle -> mem_we=0 the following cycle; count=0; mem_addr=BASE_ADDR; in_ready=1.
